ipsxe_floating_point_multiplier_pipe_v1_0: RTL and testbench
============================================================

// Module: ipsxe_floating_point_multiplier_pipe_v1_0
// PURPOSE
//  Parametrised, valid-tracked mantissa multiplier for the FMA/reciprocal datapath. It is the successor to the fixed
//  single-precision multiplier. Output is the unrounded product {sign, exp_a+exp_b, man_a*man_b}.
//  The mantissa product is built by an accumulate pipeline over CHUNK_W-bit slices of b. Any precision is supported.
//  A user sideband and an optional special-value classifier travel with each operand pair.
// PARAMETERS
//  EXP_WIDTH  8   exponent field width
//  MAN_WIDTH  23  stored mantissa width; the hidden bit is added internally
//  CHUNK_W    8   slice width of b's mantissa; NCHUNK = ceil((MAN_WIDTH+1)/CHUNK_W)
//  USER_W     1   width of the sideband carried alongside the data
// PORTS
//  i_clk      in   1                       clock, rising edge
//  i_rst      in   1                       asynchronous reset, active high
//  i_aclken   in   1                       clock enable; low freezes every register
//  i_valid    in   1                       i_a/i_b/i_user are valid this cycle
//  i_a        in   1+EXP_WIDTH+MAN_WIDTH   operand a {sign, exp, man}
//  i_b        in   1+EXP_WIDTH+MAN_WIDTH   operand b
//  i_user     in   USER_W                  sideband, passed through unchanged
//  o_valid    out  1                       o_a_mul_b/o_user/o_flags valid
//  o_a_mul_b  out  2*(MAN_WIDTH+1)+EXP_WIDTH+2  {sign, exp_sum[EXP_WIDTH:0], product[2*(MAN_WIDTH+1)-1:0]}
//  o_user     out  USER_W                  delayed i_user
//  o_flags    out  4                       {nan, inf, zero, invalid}
// BEHAVIOUR
//  - Reset: every pipeline register clears. o_valid=0, o_a_mul_b=0, o_user=0, o_flags=0.
//  - Latency: fixed LAT = NCHUNK+1 enabled cycles (the input register plus one stage per chunk).
//    Throughput is 1 per enabled cycle. There is no backpressure.
//  - i_aclken=0: data and valid registers all hold; o_valid stays asserted if it was asserted.
//  - Bubbles: valid is carried in a LAT-deep shift register. Data registers load regardless of valid.
//    Outputs are qualified only by o_valid.
//  - Sign: a[MSB]^b[MSB].
//  - exp_sum: zero-extended exp_a + exp_b, EXP_WIDTH+1 bits. Unbiased value = exp_sum - 2*bias. No overflow checks.
//  - Mantissa: ma={h_a,man_a}, mb={h_b,man_b}. mb is split into slices s_k = mb[k*CHUNK_W +: CHUNK_W].
//    The top slice is zero-padded.
//    Stage k: acc_k = acc_{k-1} + ((ma*s_k) << k*CHUNK_W), with acc_{-1}=0.
//    acc is 2*(MAN_WIDTH+1) bits and never overflows.
//  - Product format: the product MSB position is 2*MAN_WIDTH+1. Result in [1,2) gives bit 2*MAN_WIDTH set;
//    result in [2,4) gives the MSB set. Normalisation is downstream.
//  - Mid-operation reset: in-flight data is discarded and o_valid falls immediately (asynchronous).
//  - Simultaneous reset and aclken: reset dominates.
// CONFIGURATION
//  Macro IPSXE_FPM_SPECIAL_EN:
//  - Defined:
//    - Hidden bit h = |exp; exp==0 means zero/denormal, which is flushed to zero.
//    - Per-operand classification: exp==all-ones with man!=0 is NaN; exp==all-ones with man==0 is inf; exp==0 is zero.
//    - nan = nanA|nanB|(infA&zeroB)|(zeroA&infB).
//    - invalid = (infA&zeroB)|(zeroA&infB).
//    - inf = (infA|infB)&!nan.
//    - zero = (zeroA|zeroB)&!nan&!inf.
//    - Flags are registered alongside the data and have the same latency.
//  - Undefined: h is always 1 (legacy behaviour), o_flags is tied to 0, and the classifier logic is absent.
// STRUCTURE
//  - Shared package ipsxe_floating_point_pkg_v1_0: NCHUNK/LAT computation function, flag bit indices
//    (FLG_NAN=3, FLG_INF=2, FLG_ZERO=1, FLG_INV=0), field-slice localparams.
//  - Sub-module ipsxe_floating_point_mac_stage_v1_0 (one per chunk):
//    - Registered acc_out = acc_in + (ma*s << SHIFT).
//    - Forwards ma, the remaining slices, and the sign/exp/user/flags.
//    - Generate loop over NCHUNK; maps onto one APM per stage when CHUNK_W<=17.
//  - Existing ipsxe_floating_point_register_v1_0 is reused for the sideband delay; its reset polarity is adapted.
// TESTING (defaults, LAT=4)
//  - 3F800000*3F800000, valid at cycle 0 -> o_valid at cycle 4, sign=0, exp_sum=9'h0FE, product=48'h4000_0000_0000.
//  - 3FC00000*3FC00000 -> exp_sum=9'h0FE, product=48'h9000_0000_0000.
//    C0000000*40400000 -> sign=1, exp_sum=9'h100, product=48'h6000_0000_0000.
//  - 3FFFFFFF*3FFFFFFF -> product=48'hFFFF_FE00_0001, exp_sum=9'h0FE (full carry chain).
//  - Back-to-back stream of 10 pairs with bubbles, i_user=index, i_aclken toggled randomly
//    -> every result and user tag matches the reference model, in order, after 4 enabled cycles.
//  - Reset asserted with 3 in flight -> o_valid=0 and outputs=0 at once; first post-reset input emerges at LAT.
//  - SPECIAL_EN: 7F800000*00000000 -> flags=4'b1001; 7F800000*3F800000 -> 4'b0100;
//    00000001*3F800000 -> 4'b0010 with product 0. Without the macro, flags=0 for all three.

Source files
------------

// File: rtl/ipsxe_floating_point_pkg_v1_0.sv
// rtl/ipsxe_floating_point_pkg_v1_0.sv - shared constants and helpers for the floating-point multiplier
package ipsxe_floating_point_pkg_v1_0;

    localparam int FLG_NAN  = 3;
    localparam int FLG_INF  = 2;
    localparam int FLG_ZERO = 1;
    localparam int FLG_INV  = 0;
    localparam int FLAG_W   = 4;

    // Number of CHUNK_W slices covering the mantissa including its hidden bit
    function automatic int calc_nchunk(input int man_width, input int chunk_w);
        return (man_width + chunk_w) / chunk_w;
    endfunction

    function automatic int calc_lat(input int man_width, input int chunk_w);
        return calc_nchunk(man_width, chunk_w) + 1;
    endfunction

    function automatic int sign_bit(input int exp_width, input int man_width);
        return exp_width + man_width;
    endfunction

    function automatic int exp_lsb(input int man_width);
        return man_width;
    endfunction

endpackage

// File: rtl/ipsxe_floating_point_mac_stage_v1_0.sv
// rtl/ipsxe_floating_point_mac_stage_v1_0.sv - one accumulate stage: acc_out = acc_in + (ma * slice << SHIFT)
module ipsxe_floating_point_mac_stage_v1_0 #(
    parameter int MANW    = 24,
    parameter int PW      = 48,
    parameter int MBW     = 24,
    parameter int CHUNK_W = 8,
    parameter int SHIFT   = 0,
    parameter int SIDE_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [PW-1:0]     acc_in,
    input  logic [MANW-1:0]   ma_in,
    input  logic [MBW-1:0]    mb_in,
    input  logic [SIDE_W-1:0] side_in,
    output logic [PW-1:0]     acc_out,
    output logic [MANW-1:0]   ma_out,
    output logic [MBW-1:0]    mb_out,
    output logic [SIDE_W-1:0] side_out
);

    logic [PW-1:0]     partial;
    logic [PW-1:0]     acc_d, acc_q;
    logic [MANW-1:0]   ma_d, ma_q;
    logic [MBW-1:0]    mb_d, mb_q;
    logic [SIDE_W-1:0] side_d, side_q;

    always_comb begin
        partial = PW'(ma_in) * PW'(mb_in[SHIFT +: CHUNK_W]);
        acc_d   = acc_in + (partial << SHIFT);
        ma_d    = ma_in;
        mb_d    = mb_in;
        side_d  = side_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            ma_q   <= '0;
            mb_q   <= '0;
            side_q <= '0;
        end else if (ce) begin
            acc_q  <= acc_d;
            ma_q   <= ma_d;
            mb_q   <= mb_d;
            side_q <= side_d;
        end
    end

    assign acc_out  = acc_q;
    assign ma_out   = ma_q;
    assign mb_out   = mb_q;
    assign side_out = side_q;

endmodule

// File: rtl/ipsxe_floating_point_register_v1_0.sv
// rtl/ipsxe_floating_point_register_v1_0.sv - enabled delay line with asynchronous active-high reset
module ipsxe_floating_point_register_v1_0 #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe_d;
    logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

    always_comb begin
        pipe_d = pipe_q;
        if (ce) begin
            pipe_d[0] = d;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign q = pipe_q[DEPTH-1];

endmodule

// File: rtl/ipsxe_floating_point_multiplier_pipe_v1_0.sv
// rtl/ipsxe_floating_point_multiplier_pipe_v1_0.sv - pipelined unrounded FP multiply; IPSXE_FPM_SPECIAL_EN adds flush/classifier
module ipsxe_floating_point_multiplier_pipe_v1_0
    import ipsxe_floating_point_pkg_v1_0::*;
#(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    parameter int CHUNK_W   = 8,
    parameter int USER_W    = 1
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_aclken,
    input  logic                                 i_valid,
    input  logic [EXP_WIDTH+MAN_WIDTH:0]         i_a,
    input  logic [EXP_WIDTH+MAN_WIDTH:0]         i_b,
    input  logic [USER_W-1:0]                    i_user,
    output logic                                 o_valid,
    output logic [2*(MAN_WIDTH+1)+EXP_WIDTH+1:0] o_a_mul_b,
    output logic [USER_W-1:0]                    o_user,
    output logic [3:0]                           o_flags
);

    localparam int MANW     = MAN_WIDTH + 1;
    localparam int PW       = 2 * MANW;
    localparam int NCHUNK   = calc_nchunk(MAN_WIDTH, CHUNK_W);
    localparam int LAT      = calc_lat(MAN_WIDTH, CHUNK_W);
    localparam int MBW      = NCHUNK * CHUNK_W;
    localparam int ESW      = EXP_WIDTH + 1;
    localparam int SIGN_BIT = sign_bit(EXP_WIDTH, MAN_WIDTH);
    localparam int EXP_LSB  = exp_lsb(MAN_WIDTH);
`ifdef IPSXE_FPM_SPECIAL_EN
    localparam int SIDE_W   = 1 + ESW + FLAG_W;
`else
    localparam int SIDE_W   = 1 + ESW;
`endif

    logic [EXP_WIDTH-1:0] exp_a, exp_b;
    logic [MAN_WIDTH-1:0] man_a, man_b;
    logic                 h_a, h_b;
    logic [MANW-1:0]      ma_d, ma_q;
    logic [MBW-1:0]       mb_d, mb_q;
    logic [SIDE_W-1:0]    side_d, side_q;

    assign exp_a = i_a[EXP_LSB +: EXP_WIDTH];
    assign exp_b = i_b[EXP_LSB +: EXP_WIDTH];
    assign man_a = i_a[MAN_WIDTH-1:0];
    assign man_b = i_b[MAN_WIDTH-1:0];

`ifdef IPSXE_FPM_SPECIAL_EN
    logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic              invalid, nan, inf, zero;
    logic [FLAG_W-1:0] flags_d;

    always_comb begin
        nan_a   = (&exp_a) & (|man_a);
        nan_b   = (&exp_b) & (|man_b);
        inf_a   = (&exp_a) & ~(|man_a);
        inf_b   = (&exp_b) & ~(|man_b);
        zero_a  = ~(|exp_a);
        zero_b  = ~(|exp_b);
        invalid = (inf_a & zero_b) | (zero_a & inf_b);
        nan     = nan_a | nan_b | invalid;
        inf     = (inf_a | inf_b) & ~nan;
        zero    = (zero_a | zero_b) & ~nan & ~inf;
        flags_d = '0;
        flags_d[FLG_NAN]  = nan;
        flags_d[FLG_INF]  = inf;
        flags_d[FLG_ZERO] = zero;
        flags_d[FLG_INV]  = invalid;
    end

    // exp==0 operands are flushed to zero by clearing the whole significand
    assign h_a = |exp_a;
    assign h_b = |exp_b;
`else
    assign h_a = 1'b1;
    assign h_b = 1'b1;
`endif

    always_comb begin
        ma_d = {h_a, man_a} & {MANW{h_a}};
        mb_d = MBW'({h_b, man_b} & {MANW{h_b}});
`ifdef IPSXE_FPM_SPECIAL_EN
        side_d = {i_a[SIGN_BIT] ^ i_b[SIGN_BIT], {1'b0, exp_a} + {1'b0, exp_b}, flags_d};
`else
        side_d = {i_a[SIGN_BIT] ^ i_b[SIGN_BIT], {1'b0, exp_a} + {1'b0, exp_b}};
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ma_q   <= '0;
            mb_q   <= '0;
            side_q <= '0;
        end else if (i_aclken) begin
            ma_q   <= ma_d;
            mb_q   <= mb_d;
            side_q <= side_d;
        end
    end

    logic [PW-1:0]     acc_w  [0:NCHUNK];
    logic [MANW-1:0]   ma_w   [0:NCHUNK];
    logic [MBW-1:0]    mb_w   [0:NCHUNK];
    logic [SIDE_W-1:0] side_w [0:NCHUNK];

    assign acc_w[0]  = '0;
    assign ma_w[0]   = ma_q;
    assign mb_w[0]   = mb_q;
    assign side_w[0] = side_q;

    for (genvar k = 0; k < NCHUNK; k++) begin : g_stage
        ipsxe_floating_point_mac_stage_v1_0 #(
            .MANW    (MANW),
            .PW      (PW),
            .MBW     (MBW),
            .CHUNK_W (CHUNK_W),
            .SHIFT   (k * CHUNK_W),
            .SIDE_W  (SIDE_W)
        ) u_stage (
            .clk      (i_clk),
            .rst      (i_rst),
            .ce       (i_aclken),
            .acc_in   (acc_w[k]),
            .ma_in    (ma_w[k]),
            .mb_in    (mb_w[k]),
            .side_in  (side_w[k]),
            .acc_out  (acc_w[k+1]),
            .ma_out   (ma_w[k+1]),
            .mb_out   (mb_w[k+1]),
            .side_out (side_w[k+1])
        );
    end

    // Valid and sideband share one LAT-deep delay so they stay aligned with the data
    logic [USER_W:0] vu_q;

    ipsxe_floating_point_register_v1_0 #(
        .WIDTH (USER_W + 1),
        .DEPTH (LAT)
    ) u_vu_delay (
        .clk (i_clk),
        .rst (i_rst),
        .ce  (i_aclken),
        .d   ({i_valid, i_user}),
        .q   (vu_q)
    );

    assign o_valid   = vu_q[USER_W];
    assign o_user    = vu_q[USER_W-1:0];
    assign o_a_mul_b = {side_w[NCHUNK][SIDE_W-1 -: 1+ESW], acc_w[NCHUNK]};
`ifdef IPSXE_FPM_SPECIAL_EN
    assign o_flags   = side_w[NCHUNK][FLAG_W-1:0];
`else
    assign o_flags   = 4'b0;
`endif

endmodule

// File: tb/tb_ipsxe_floating_point_multiplier_pipe_v1_0.sv
// tb/tb_ipsxe_floating_point_multiplier_pipe_v1_0.sv - scoreboard bench for the pipelined FP multiplier
module tb_ipsxe_floating_point_multiplier_pipe_v1_0;

    localparam int LAT = 4;
    localparam int UW  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        aclken;
    logic        valid;
    logic [31:0] a, b;
    logic [UW-1:0] user;
    logic        o_valid;
    logic [57:0] o_mul;
    logic [UW-1:0] o_user;
    logic [3:0]  o_flags;

    always #5 clk = ~clk;

    ipsxe_floating_point_multiplier_pipe_v1_0 #(
        .EXP_WIDTH (8),
        .MAN_WIDTH (23),
        .CHUNK_W   (8),
        .USER_W    (UW)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_aclken  (aclken),
        .i_valid   (valid),
        .i_a       (a),
        .i_b       (b),
        .i_user    (user),
        .o_valid   (o_valid),
        .o_a_mul_b (o_mul),
        .o_user    (o_user),
        .o_flags   (o_flags)
    );

`ifdef IPSXE_FPM_SPECIAL_EN
    localparam logic [3:0]  F_INV  = 4'b1001;
    localparam logic [3:0]  F_INF  = 4'b0100;
    localparam logic [3:0]  F_ZERO = 4'b0010;
    localparam logic [47:0] P_INV  = 48'h0;
    localparam logic [47:0] P_DEN  = 48'h0;
`else
    localparam logic [3:0]  F_INV  = 4'b0000;
    localparam logic [3:0]  F_INF  = 4'b0000;
    localparam logic [3:0]  F_ZERO = 4'b0000;
    localparam logic [47:0] P_INV  = 48'h4000_0000_0000;
    localparam logic [47:0] P_DEN  = 48'h4000_0080_0000;
`endif

    typedef struct {
        logic [57:0]   data;
        logic [3:0]    flags;
        logic [UW-1:0] user;
        int            due;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   ecnt   = 0;

    logic [31:0] tbl [0:9] = '{32'h3F800000, 32'h40490FDB, 32'hC2F6E979, 32'h3DCCCCCD, 32'h477FE000,
                               32'hBF000001, 32'h00800000, 32'h7F7FFFFF, 32'h41200000, 32'hC1A80000};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, want);
    endtask

    function automatic logic [57:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        logic [47:0] p;
        p = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
        return {x[31] ^ y[31], {1'b0, x[30:23]} + {1'b0, y[30:23]}, p};
    endfunction

    always begin : monitor
        logic en_s;
        exp_t e;
        @(posedge clk);
        en_s = aclken && !rst;
        if (en_s) ecnt++;
        @(negedge clk);
        if (en_s && o_valid && !rst) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("data", 64'(o_mul), 64'(e.data));
                check("user", 64'(o_user), 64'(e.user));
                check("flags", 64'(o_flags), 64'(e.flags));
                check("latency", 64'(ecnt), 64'(e.due));
            end
        end
    end

    task automatic drive(input logic v, input logic en, input logic [31:0] ta, input logic [31:0] tb2,
                         input logic [UW-1:0] u, input logic [57:0] xd, input logic [3:0] xf);
        @(posedge clk);
        #2;
        valid  = v;
        aclken = en;
        a      = ta;
        b      = tb2;
        user   = u;
        if (v && en) sb.push_back('{xd, xf, u, ecnt + LAT});
    endtask

    task automatic idle();
        drive(1'b0, 1'b1, 32'h0, 32'h0, '0, '0, '0);
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while (sb.size() != 0 && i < 50) begin
            idle();
            i++;
        end
        check(name, 64'(sb.size()), 64'd0);
        idle();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int acc;
        int guard;
        logic v, en;
        rst = 1'b1; aclken = 1'b1; valid = 1'b0; a = '0; b = '0; user = '0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_valid", 64'(o_valid), 64'd0);
        check("reset_data", 64'(o_mul), 64'd0);
        check("reset_user", 64'(o_user), 64'd0);
        check("reset_flags", 64'(o_flags), 64'd0);
        rst = 1'b0;

        drive(1, 1, 32'h3F800000, 32'h3F800000, 4'd1, {1'b0, 9'h0FE, 48'h4000_0000_0000}, 4'b0);
        drive(1, 1, 32'h3FC00000, 32'h3FC00000, 4'd2, {1'b0, 9'h0FE, 48'h9000_0000_0000}, 4'b0);
        drive(1, 1, 32'hC0000000, 32'h40400000, 4'd3, {1'b1, 9'h100, 48'h6000_0000_0000}, 4'b0);
        drive(1, 1, 32'h3FFFFFFF, 32'h3FFFFFFF, 4'd4, {1'b0, 9'h0FE, 48'hFFFF_FE00_0001}, 4'b0);
        drive(1, 1, 32'h7F800000, 32'h00000000, 4'd5, {1'b0, 9'h0FF, P_INV}, F_INV);
        drive(1, 1, 32'h7F800000, 32'h3F800000, 4'd6, {1'b0, 9'h17E, 48'h4000_0000_0000}, F_INF);
        drive(1, 1, 32'h00000001, 32'h3F800000, 4'd7, {1'b0, 9'h07F, P_DEN}, F_ZERO);
        drain("drain_directed");

        acc = 0;
        guard = 0;
        while (acc < 10 && guard < 400) begin
            v  = ($urandom_range(0, 3) != 0);
            en = ($urandom_range(0, 2) != 0);
            drive(v, en, tbl[acc], tbl[(acc + 3) % 10], UW'(acc),
                  ref_mul(tbl[acc], tbl[(acc + 3) % 10]), 4'b0);
            if (v && en) acc++;
            guard++;
        end
        check("stream_issued", 64'(acc), 64'd10);
        drain("drain_stream");

        drive(1, 1, 32'h3F800000, 32'h3F800000, 4'd8, {1'b0, 9'h0FE, 48'h4000_0000_0000}, 4'b0);
        drive(1, 1, 32'h3FC00000, 32'h3FC00000, 4'd9, {1'b0, 9'h0FE, 48'h9000_0000_0000}, 4'b0);
        drive(1, 1, 32'hC0000000, 32'h40400000, 4'd10, {1'b1, 9'h100, 48'h6000_0000_0000}, 4'b0);
        idle();
        rst = 1'b1;
        #1;
        check("midreset_valid", 64'(o_valid), 64'd0);
        check("midreset_data", 64'(o_mul), 64'd0);
        check("midreset_user", 64'(o_user), 64'd0);
        check("midreset_flags", 64'(o_flags), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        drive(1, 1, 32'h40400000, 32'h40400000, 4'd11, {1'b0, 9'h100, 48'h9000_0000_0000}, 4'b0);
        drain("drain_post_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
